add64_seq: RTL and testbench

ADD64_SEQ -- requirements
Module: add64_seq

---
 rtl/add64_seq_pkg.sv | 14 +
 rtl/add64_seq_cla16.sv | 60 ++++++
 rtl/add64_seq.sv | 125 ++++++++++++
 tb/tb_add64_seq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/add64_seq_pkg.sv
// add64_seq_pkg: shared types and constants for the sequential slice adder.
//   SLICE_W : width of one adder slice (the CLA16 datapath width)
//   state_t : controller state encoding
package add64_seq_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add64_seq_cla16.sv
// CLA16: 16-bit carry-lookahead adder built from four 4-bit lookahead groups.
// Ports:
//   A, B : 16-bit operands
//   Ci   : carry in
//   S    : 16-bit sum
//   Co   : carry out
//   PG   : block propagate (all 16 bits propagate)
//   GG   : block generate (carry out with Ci = 0)
module CLA16 (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Ci,
  output logic [15:0] S,
  output logic        Co,
  output logic        PG,
  output logic        GG
);

  logic [15:0] p;
  logic [15:0] g;
  logic [15:0] c;
  logic [3:0]  gp;
  logic [3:0]  gg;
  logic        carry_run;
  logic        gen_run;

  always_comb begin
    p         = A ^ B;
    g         = A & B;
    gp        = '0;
    gg        = '0;
    c         = '0;
    carry_run = Ci;
    gen_run   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      // Bit carries inside the group are expanded from the group carry-in
      // so no bit waits on its neighbour.
      c[4*k]   = carry_run;
      c[4*k+1] = g[4*k] | (p[4*k] & carry_run);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & carry_run);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & carry_run);
      carry_run = gg[k] | (gp[k] & carry_run);
      gen_run   = gg[k] | (gp[k] & gen_run);
    end
  end

  assign S  = p ^ c;
  assign Co = carry_run;
  assign PG = &gp;
  assign GG = gen_run;

endmodule

// File: rtl/add64_seq.sv
// add64_seq: W-bit add/subtract computed one 16-bit slice per cycle through
// a single shared CLA16, with valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : request handshake (accepted only in IDLE)
//   a, b, sub, cin      : operands and op select (sub=1 -> a-b, cin ignored)
//   out_valid/out_ready : result handshake (result held in DONE)
//   sum, cout, ovf      : result, final carry (no-borrow for sub), signed ovf
//   busy                : operation in progress or waiting for consumer
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready high
// RUN   | one slice per cycle, LSB slice first
// DONE  | result held until out_ready
module add64_seq
  import add64_seq_pkg::*;
#(
  parameter int SLICES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SLICE_W*SLICES-1:0] a,
  input  logic [SLICE_W*SLICES-1:0] b,
  input  logic                    sub,
  input  logic                    cin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SLICE_W*SLICES-1:0] sum,
  output logic                    cout,
  output logic                    ovf,
  output logic                    busy
);

  localparam int W     = SLICE_W * SLICES;
  localparam int IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SLICES - 1);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [W-1:0]       a_r;
  logic [W-1:0]       b_r;
  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_co;

  assign slice_a = a_r[idx*SLICE_W +: SLICE_W];
  assign slice_b = b_r[idx*SLICE_W +: SLICE_W];

  CLA16 u_cla (
    .A  (slice_a),
    .B  (slice_b),
    .Ci (carry),
    .S  (slice_s),
    .Co (slice_co),
    .PG (),
    .GG ()
  );

  // Handshake/status outputs are flops updated alongside state so they
  // never see a combinational path from the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            // Subtraction is a + ~b + 1; the +1 rides in as the carry.
            b_r      <= sub ? ~b : b;
            carry    <= sub ? 1'b1 : cin;
            idx      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          sum[idx*SLICE_W +: SLICE_W] <= slice_s;
          carry <= slice_co;
          if (idx == IDX_LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            cout      <= slice_co;
            // Top slice sum bit is the result sign; it is not yet in sum.
            ovf       <= (a_r[W-1] == b_r[W-1]) &
                         (slice_s[SLICE_W-1] != a_r[W-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          idx       <= '0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add64_seq.sv
// Self-checking bench for add64_seq with a behavioural arithmetic model.
module tb_add64_seq;

  localparam int SLICES = 4;
  localparam int W      = 16 * SLICES;
  localparam int LAT    = SLICES + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  add64_seq #(.SLICES(SLICES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  // Plain arithmetic: unsigned result/carry, and signed overflow as
  // "the exact signed result does not fit in W bits".
  function automatic void ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                    input logic rsub, input logic rcin,
                                    output logic [W-1:0] rs, output logic rc,
                                    output logic ro);
    logic [W:0]   wide;
    logic [W+1:0] sr;
    logic [W+1:0] sa;
    logic [W+1:0] sb;
    sa = {{2{ra[W-1]}}, ra};
    sb = {{2{rb[W-1]}}, rb};
    if (!rsub) begin
      wide = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rcin};
      rs   = wide[W-1:0];
      rc   = wide[W];
      sr   = sa + sb + {{(W+1){1'b0}}, rcin};
    end else begin
      rs = ra - rb;
      rc = (ra >= rb);
      sr = sa - sb;
    end
    ro = (sr[W+1:W-1] != {3{sr[W-1]}});
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '1;
      1:       v = {1'b0, {(W-1){1'b1}}};
      2:       v = {1'b1, {(W-1){1'b0}}};
      3:       v = W'($urandom_range(0, 3));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Drives one operation from IDLE; scrambles the inputs after the accept
  // edge and measures edges from accept (counted as 1) to out_valid.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tsub, input logic tcin,
                       output logic [W-1:0] rs, output logic rc,
                       output logic ro, output int lat);
    a = ta; b = tb; sub = tsub; cin = tcin;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    sub = 1'($urandom); cin = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = sum; rc = cout; ro = ovf;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    #12;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_cmp++; if (sum !== '0) begin n_bad++; $display("FAIL reset_sum got %h exp 0", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL reset_cout got %b exp 0", cout); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vsub;
    logic         vcin;
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
  } vec_t;

  task automatic test_directed();
    vec_t         v[4];
    logic [W-1:0] rs;
    logic         rc;
    logic         ro;
    int           lat;
    v[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
    v[1] = '{64'h5, 64'h7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    v[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    v[3] = '{64'h0, 64'h0, 1'b0, 1'b1, 64'h1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      do_op(v[i].va, v[i].vb, v[i].vsub, v[i].vcin, rs, rc, ro, lat);
      n_cmp++; if (rs !== v[i].es) begin n_bad++; $display("FAIL dir%0d_sum got %h exp %h", i, rs, v[i].es); end
      n_cmp++; if (rc !== v[i].ec) begin n_bad++; $display("FAIL dir%0d_cout got %b exp %b", i, rc, v[i].ec); end
      n_cmp++; if (ro !== v[i].eo) begin n_bad++; $display("FAIL dir%0d_ovf got %b exp %b", i, ro, v[i].eo); end
      n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, LAT); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ta, tb, rs, es;
    logic         ts, tc, rc, ro, ec, eo;
    int           lat;
    for (int i = 0; i < 40; i++) begin
      ta = rand_w(); tb = rand_w();
      ts = 1'($urandom); tc = 1'($urandom);
      ref_model(ta, tb, ts, tc, es, ec, eo);
      do_op(ta, tb, ts, tc, rs, rc, ro, lat);
      n_cmp++; if (rs !== es) begin n_bad++; $display("FAIL rnd%0d_sum got %h exp %h", i, rs, es); end
      n_cmp++; if (rc !== ec) begin n_bad++; $display("FAIL rnd%0d_cout got %b exp %b", i, rc, ec); end
      n_cmp++; if (ro !== eo) begin n_bad++; $display("FAIL rnd%0d_ovf got %b exp %b", i, ro, eo); end
      n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL rnd%0d_latency got %0d exp %0d", i, lat, LAT); end
    end
  endtask

  task automatic test_backpressure();
    int wait_cnt;
    a = 64'd3; b = 64'd4; sub = 1'b0; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    a = 64'd100; b = 64'd1;
    wait_cnt = 0;
    while (!out_valid && wait_cnt < 20) begin @(posedge clk); #1; wait_cnt++; end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_first_done got %b exp 1", out_valid); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold%0d_valid got %b exp 1", i, out_valid); end
      n_cmp++; if (sum !== 64'd7) begin n_bad++; $display("FAIL bp_hold%0d_sum got %h exp 7", i, sum); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold%0d_in_ready got %b exp 0", i, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_released got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL bp_second_accept got busy=%b exp 1", busy); end
    wait_cnt = 0;
    while (!out_valid && wait_cnt < 20) begin @(posedge clk); #1; wait_cnt++; end
    n_cmp++; if (sum !== 64'd101 || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL bp_second_sum got %h valid=%b exp 65/1", sum, out_valid);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int accepts[$];
    int wait_cnt;
    a = 64'h1111_2222_3333_4444; b = 64'h0101_0101_0101_0101;
    sub = 1'b0; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (in_ready) accepts.push_back(cyc);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_cmp++; if (accepts.size() != 4) begin n_bad++; $display("FAIL b2b_count got %0d exp 4", accepts.size()); end
    for (int i = 1; i < accepts.size(); i++) begin
      n_cmp++;
      if (accepts[i] - accepts[i-1] != SLICES + 2) begin
        n_bad++; $display("FAIL b2b_gap%0d got %0d exp %0d", i, accepts[i] - accepts[i-1], SLICES + 2);
      end
    end
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 20) begin @(posedge clk); #1; wait_cnt++; end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_drain got %b exp 1", in_ready); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] rs;
    logic         rc, ro;
    int           lat;
    a = 64'hAAAA_AAAA_AAAA_AAAA; b = 64'h5555_5555_5555_5555;
    sub = 1'b0; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_in_ready got %b exp 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
    n_cmp++; if (sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_bad++; $display("FAIL mid_rst_result got sum=%h cout=%b ovf=%b exp 0/0/0", sum, cout, ovf);
    end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_hold got %b exp 0", out_valid); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL mid_rst_no_result got valid=%b busy=%b exp 0/0", out_valid, busy);
    end
    do_op(64'h1234, 64'h1, 1'b0, 1'b0, rs, rc, ro, lat);
    n_cmp++; if (rs !== 64'h1235) begin n_bad++; $display("FAIL mid_rst_after_sum got %h exp 1235", rs); end
    n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL mid_rst_after_latency got %0d exp %0d", lat, LAT); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
